// File: rtl/sas_pkg.sv
// Shared SAS-L2 client definitions: state codes decoded by the sequencer,
// adr_reg and the datapath, plus the An/Mn address select values.
package sas_pkg;

    // State encoding is fixed; the datapath decodes these codes directly.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_GEN   = 3'b001,
        ST_SEND  = 3'b010,
        ST_RECV  = 3'b011,
        ST_UPD_M = 3'b100,
        ST_UPD_A = 3'b101,
        ST_DONE  = 3'b110,
        ST_ERR   = 3'b111
    } sas_st_e;

    localparam logic ADR_AN = 1'b0;
    localparam logic ADR_MN = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/adr_reg.sv
// An/Mn address select decode from the client state code.
module adr_reg
    import sas_pkg::*;
(
    input  logic [2:0] st,
    output logic       adr
);

    // Mn is addressed while idle and while Mn is being written; An otherwise.
    assign adr = (st == ST_IDLE || st == ST_UPD_M) ? ADR_MN : ADR_AN;

endmodule

// File: rtl/sas_client_seq.sv
// SAS-L2 client authentication sequencer: one round of
// GEN -> SEND -> RECV -> UPD_M -> UPD_A -> DONE, with RECV timeout to ERR.
module sas_client_seq
    import sas_pkg::*;
#(
    parameter int WAIT_CYC = 3,
    parameter int TIMEOUT  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       tx_ready,
    input  logic       rx_valid,
    output logic [2:0] st,
    output logic       adr,
    output logic       tx_valid,
    output logic       rx_ld,
    output logic       mn_we,
    output logic       an_we,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int CW = $clog2(max_int(WAIT_CYC, TIMEOUT) + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYC - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    sas_st_e       st_q, st_d;
    logic [CW-1:0] wait_q, wait_d;
    logic [CW-1:0] tmo_q, tmo_d;

    // State and counter registers; reset aborts any round in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= ST_IDLE;
            wait_q <= '0;
            tmo_q  <= '0;
        end else begin
            st_q   <= st_d;
            wait_q <= wait_d;
            tmo_q  <= tmo_d;
        end
    end

    // Next-state logic; counters saturate rather than wrap.
    always_comb begin
        st_d   = st_q;
        wait_d = wait_q;
        tmo_d  = tmo_q;
        case (st_q)
            ST_IDLE: begin
                if (start) begin
                    st_d   = ST_GEN;
                    wait_d = '0;
                end
            end
            ST_GEN: begin
                if (wait_q == WAIT_LAST) begin
                    st_d = ST_SEND;
                end else if (wait_q != CNT_MAX) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_SEND: begin
                if (tx_ready) begin
                    st_d  = ST_RECV;
                    tmo_d = '0;
                end
            end
            ST_RECV: begin
                // A response arriving on the expiry cycle still counts.
                if (rx_valid) begin
                    st_d = ST_UPD_M;
                end else if (TIMEOUT > 0 && tmo_q == TMO_LAST) begin
                    st_d = ST_ERR;
                end else if (tmo_q != CNT_MAX) begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_UPD_M: st_d = ST_UPD_A;
            ST_UPD_A: st_d = ST_DONE;
            ST_DONE:  st_d = ST_IDLE;
            ST_ERR:   st_d = ST_IDLE;
            default:  st_d = ST_IDLE;
        endcase
    end

    adr_reg u_adr_reg (
        .st  (st_q),
        .adr (adr)
    );

    // Strobes are state decodes, masked while reset is asserted so an
    // aborted round never fires a write on the reset cycle.
    assign st       = st_q;
    assign busy     = (st_q != ST_IDLE);
    assign tx_valid = ~rst & (st_q == ST_SEND);
    assign rx_ld    = ~rst & (st_q == ST_RECV) & rx_valid;
    assign mn_we    = ~rst & (st_q == ST_UPD_M);
    assign an_we    = ~rst & (st_q == ST_UPD_A);
    assign done     = ~rst & (st_q == ST_DONE);
    assign err      = ~rst & (st_q == ST_ERR);

endmodule

// File: tb/tb_sas_client_seq.sv
// Scoreboard bench for sas_client_seq (WAIT_CYC=3, TIMEOUT=16).
module tb_sas_client_seq;

    localparam logic [2:0] IDLE = 3'd0, GEN = 3'd1, SEND = 3'd2, RECV = 3'd3,
                           UPDM = 3'd4, UPDA = 3'd5, DONE = 3'd6, ERR = 3'd7;

    logic       clk = 1'b0;
    logic       rst, start, tx_ready, rx_valid;
    logic [2:0] st;
    logic       adr, tx_valid, rx_ld, mn_we, an_we, busy, done, err;

    int n_cmp = 0;
    int n_err = 0;
    int n_cyc = 0;
    logic [10:0] sb_q[$];

    always #5 clk = ~clk;

    sas_client_seq #(.WAIT_CYC(3), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .st(st), .adr(adr), .tx_valid(tx_valid),
        .rx_ld(rx_ld), .mn_we(mn_we), .an_we(an_we), .busy(busy),
        .done(done), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected {st,adr,busy,tx_valid,rx_ld,mn_we,an_we,done,err} for a cycle.
    function automatic logic [10:0] exp_of(input logic [2:0] s, input logic rv, input logic r);
        logic a;
        a = (s == IDLE) || (s == UPDM);
        return {s, a, s != IDLE, !r && s == SEND, !r && s == RECV && rv,
                !r && s == UPDM, !r && s == UPDA, !r && s == DONE, !r && s == ERR};
    endfunction

    // One cycle: after the edge, expect state s and drive the given inputs.
    task automatic cyc(input logic r, input logic s_in, input logic tr, input logic rv,
                       input logic [2:0] s);
        @(posedge clk);
        #1;
        rst = r; start = s_in; tx_ready = tr; rx_valid = rv;
        sb_q.push_back(exp_of(s, rv, r));
    endtask

    // Monitor: compare DUT outputs against the next scoreboard entry.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            chk($sformatf("cyc%0d", n_cyc),
                {21'd0, st, adr, busy, tx_valid, rx_ld, mn_we, an_we, done, err},
                {21'd0, sb_q.pop_front()});
            n_cyc++;
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;

        // Reset: held two cycles, start ignored while in reset.
        cyc(1, 1, 1, 1, IDLE);
        cyc(1, 0, 0, 0, IDLE);

        // Nominal round; tx_ready/rx_valid high in GEN must be ignored.
        cyc(0, 1, 0, 0, IDLE);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, GEN);
        cyc(0, 0, 1, 0, SEND);
        cyc(0, 0, 0, 1, RECV);
        cyc(0, 0, 0, 0, UPDM);
        cyc(0, 0, 0, 0, UPDA);
        cyc(0, 0, 0, 0, DONE);
        cyc(0, 0, 0, 0, IDLE);

        // Backpressure in SEND, start pulsed during GEN has no effect.
        cyc(0, 1, 0, 0, IDLE);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, GEN);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, SEND);
        cyc(0, 0, 1, 0, SEND);
        cyc(0, 0, 0, 1, RECV);
        cyc(0, 0, 0, 0, UPDM);
        cyc(0, 0, 0, 0, UPDA);
        cyc(0, 0, 0, 0, DONE);
        cyc(0, 0, 0, 0, IDLE);

        // Timeout: 16 RECV cycles without rx_valid, then ERR; start held
        // through ERR into IDLE begins the next round immediately.
        cyc(0, 1, 0, 0, IDLE);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, GEN);
        cyc(0, 0, 1, 0, SEND);
        for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0, RECV);
        cyc(0, 1, 0, 0, ERR);
        cyc(0, 1, 0, 0, IDLE);

        // Race at expiry: rx_valid on the 16th RECV cycle wins.
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, GEN);
        cyc(0, 0, 1, 0, SEND);
        for (int i = 0; i < 15; i++) cyc(0, 0, 0, 0, RECV);
        cyc(0, 0, 0, 1, RECV);
        cyc(0, 0, 0, 0, UPDM);
        cyc(0, 0, 0, 0, UPDA);
        cyc(0, 1, 0, 0, DONE);
        cyc(0, 1, 0, 0, IDLE);

        // Reset while in UPD_A: no an_we, back to IDLE next cycle.
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, GEN);
        cyc(0, 0, 1, 0, SEND);
        cyc(0, 0, 0, 1, RECV);
        cyc(0, 0, 0, 0, UPDM);
        cyc(1, 0, 0, 0, UPDA);
        cyc(0, 0, 0, 0, IDLE);
        cyc(0, 0, 0, 0, IDLE);

        @(negedge clk);
        @(negedge clk);
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
